// File: rtl/coreriscv_axi4_tl_get_client.sv
// TileLink-style uncached get client: accepts one read command, issues a
// single Acquire, then streams the matching Grant beats straight through to
// the response port. Flags mismatched grants and aborts on a silent manager.
module coreriscv_axi4_tl_get_client #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [25:0] cmd_addr_block,
  input  logic [2:0]  cmd_addr_beat,
  input  logic        cmd_block,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic [2:0]  rsp_beat,
  output logic        rsp_last,
  output logic        io_acquire_valid,
  input  logic        io_acquire_ready,
  output logic [25:0] io_acquire_bits_addr_block,
  output logic [1:0]  io_acquire_bits_client_xact_id,
  output logic [2:0]  io_acquire_bits_addr_beat,
  output logic        io_acquire_bits_is_builtin_type,
  output logic [2:0]  io_acquire_bits_a_type,
  output logic [11:0] io_acquire_bits_union,
  output logic [63:0] io_acquire_bits_data,
  input  logic        io_grant_valid,
  output logic        io_grant_ready,
  input  logic [2:0]  io_grant_bits_addr_beat,
  input  logic [1:0]  io_grant_bits_client_xact_id,
  input  logic        io_grant_bits_manager_xact_id,
  input  logic        io_grant_bits_is_builtin_type,
  input  logic [3:0]  io_grant_bits_g_type,
  input  logic [63:0] io_grant_bits_data,
  output logic        busy,
  output logic        err_proto,
  output logic        err_timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACQ  = 2'd1,
    S_GNT  = 2'd2
  } state_t;

  // Watchdog fires when the count of silent GNT cycles reaches TIMEOUT_CYCLES.
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  xid_q, xid_d;
  logic [2:0]  exp_beat_q, exp_beat_d;
  logic [7:0]  wdog_q, wdog_d;
  logic        err_proto_q, err_proto_d;
  logic        err_timeout_q, err_timeout_d;
  logic [25:0] addr_block_q, addr_block_d;
  logic [2:0]  addr_beat_q, addr_beat_d;
  logic        block_q, block_d;

  logic        in_gnt;
  logic        cmd_fire;
  logic        acq_fire;
  logic        gnt_fire;
  logic        proto_bad;
  logic [3:0]  exp_g_type;

  // The manager transaction id is not needed by an uncached get client.
  logic        unused_mgr_xact_id;
  assign unused_mgr_xact_id = io_grant_bits_manager_xact_id;

  assign in_gnt   = (state_q == S_GNT);
  assign cmd_fire = cmd_valid & cmd_ready;
  assign acq_fire = io_acquire_valid & io_acquire_ready;
  assign gnt_fire = io_grant_valid & io_grant_ready;

  assign cmd_ready        = (state_q == S_IDLE);
  assign busy             = (state_q != S_IDLE);
  assign io_acquire_valid = (state_q == S_ACQ);

  // Acquire fields come only from latched state so they hold while stalled.
  assign io_acquire_bits_addr_block      = addr_block_q;
  assign io_acquire_bits_client_xact_id  = xid_q;
  assign io_acquire_bits_addr_beat       = block_q ? 3'h0 : addr_beat_q;
  assign io_acquire_bits_is_builtin_type = 1'b1;
  assign io_acquire_bits_a_type          = block_q ? 3'h1 : 3'h0;
  assign io_acquire_bits_union           = block_q ? 12'h001 : 12'h0C1;
  assign io_acquire_bits_data            = 64'h0;

  // Grant-to-response is a pure combinational pass-through while in GNT.
  assign rsp_valid      = in_gnt & io_grant_valid;
  assign io_grant_ready = in_gnt & rsp_ready;
  assign rsp_data       = in_gnt ? io_grant_bits_data : 64'h0;
  assign rsp_beat       = in_gnt ? io_grant_bits_addr_beat : 3'h0;
  assign rsp_last       = in_gnt & (~block_q | (exp_beat_q == 3'd7));

  assign exp_g_type = block_q ? 4'h5 : 4'h4;
  assign proto_bad  = (io_grant_bits_client_xact_id != xid_q) |
                      (io_grant_bits_addr_beat != exp_beat_q) |
                      ~io_grant_bits_is_builtin_type |
                      (io_grant_bits_g_type != exp_g_type);

  assign err_proto   = err_proto_q;
  assign err_timeout = err_timeout_q;

  // Next-state, beat tracking, watchdog and sticky error computation.
  always_comb begin
    state_d       = state_q;
    xid_d         = xid_q;
    exp_beat_d    = exp_beat_q;
    wdog_d        = wdog_q;
    err_proto_d   = err_proto_q;
    err_timeout_d = err_timeout_q;
    addr_block_d  = addr_block_q;
    addr_beat_d   = addr_beat_q;
    block_d       = block_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          addr_block_d = cmd_addr_block;
          addr_beat_d  = cmd_addr_beat;
          block_d      = cmd_block;
          exp_beat_d   = cmd_block ? 3'h0 : cmd_addr_beat;
          state_d      = S_ACQ;
        end
      end
      S_ACQ: begin
        if (acq_fire) begin
          wdog_d  = 8'h0;
          state_d = S_GNT;
        end
      end
      S_GNT: begin
        if (gnt_fire) begin
          wdog_d     = 8'h0;
          exp_beat_d = exp_beat_q + 3'd1;
          if (proto_bad) begin
            err_proto_d = 1'b1;
          end
          if (rsp_last) begin
            xid_d   = xid_q + 2'd1;
            state_d = S_IDLE;
          end
        end else if (wdog_q == WDOG_LAST) begin
          wdog_d        = 8'h0;
          err_timeout_d = 1'b1;
          xid_d         = xid_q + 2'd1;
          state_d       = S_IDLE;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      xid_q         <= 2'h0;
      exp_beat_q    <= 3'h0;
      wdog_q        <= 8'h0;
      err_proto_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      xid_q         <= xid_d;
      exp_beat_q    <= exp_beat_d;
      wdog_q        <= wdog_d;
      err_proto_q   <= err_proto_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // Latched command fields; only meaningful once a command is accepted.
  always_ff @(posedge clk) begin
    addr_block_q <= addr_block_d;
    addr_beat_q  <= addr_beat_d;
    block_q      <= block_d;
  end

endmodule

// File: doc/coreriscv_axi4_tl_get_client.md
CORERISCV_AXI4_TL_GET_CLIENT -- requirements
Module: coreriscv_axi4_tl_get_client

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, default 255, idle cycles allowed between grant beats in GNT before abort (1..255).
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- cmd_valid  in  1  read request valid.
- cmd_ready  out  1  request accepted when valid&ready.
- cmd_addr_block  in  26  block address.
- cmd_addr_beat  in  3  beat index (single-beat only).
- cmd_block  in  1  1 = GetBlock (8 beats), 0 = Get (1 beat).
- rsp_valid  out  1  response beat valid.
- rsp_ready  in  1  consumer accepts beat.
- rsp_data  out  64  beat data.
- rsp_beat  out  3  beat index.
- rsp_last  out  1  final beat of transaction.
- io_acquire_valid, io_acquire_ready  out/in  1/1  acquire handshake.
- io_acquire_bits_addr_block  out  26; _client_xact_id  out  2; _addr_beat  out  3; _is_builtin_type  out  1; _a_type  out  3; _union  out  12; _data  out  64.
- io_grant_valid, io_grant_ready  in/out  1/1  grant handshake.
- io_grant_bits_addr_beat  in  3; _client_xact_id  in  2; _manager_xact_id  in  1; _is_builtin_type  in  1; _g_type  in  4; _data  in  64.
- busy  out  1  transaction in flight.
- err_proto  out  1  sticky protocol-mismatch flag.
- err_timeout  out  1  sticky grant-timeout flag.

Function
REQ-003 SHALL implement FSM IDLE -> ACQ -> GNT -> IDLE; one transaction outstanding at a time.
REQ-004 cmd_ready SHALL be 1 only in IDLE; on cmd_valid&cmd_ready, latch cmd fields and enter ACQ next cycle.
REQ-005 In ACQ, io_acquire_valid SHALL be 1 with stable fields until io_acquire_ready; on that handshake enter GNT next cycle.
REQ-006 Acquire fields: is_builtin_type=1; data=0; client_xact_id=current 2-bit xid register; block: a_type=3'h1, addr_beat=3'h0, union=12'h001; single: a_type=3'h0, addr_beat=latched cmd_addr_beat, union=12'h0C1.
REQ-007 In GNT, rsp_valid SHALL equal io_grant_valid and io_grant_ready SHALL equal rsp_ready (combinational pass-through, zero added latency); rsp_data=io_grant_bits_data, rsp_beat=io_grant_bits_addr_beat; outside GNT both SHALL be 0.
REQ-008 Expected-beat counter: loads 0 (block) or cmd_addr_beat (single) on cmd accept; increments mod 8 per grant handshake.
REQ-009 rsp_last SHALL be 1 in GNT when (single) or (block and expected beat==7); grant handshake with rsp_last returns FSM to IDLE next cycle and increments xid (wraps 3->0).
REQ-010 On any grant handshake where client_xact_id!=xid, addr_beat!=expected beat, is_builtin_type!=1, or g_type!=(block?4'h5:4'h4), err_proto SHALL set; beat is still delivered and counting continues.
REQ-011 Watchdog: counter clears on entering GNT and on each grant handshake, increments each GNT cycle without handshake; reaching TIMEOUT_CYCLES sets err_timeout, returns to IDLE, increments xid, emits no further beats.
REQ-012 err_proto/err_timeout SHALL clear only on reset; busy SHALL be 1 in ACQ and GNT.
REQ-013 Grant beats arriving in IDLE or ACQ SHALL not be accepted (io_grant_ready=0).

Reset
REQ-014 While reset==0 at a clk edge: FSM=IDLE, xid=0, beat counter=0, watchdog=0, err_proto=0, err_timeout=0.
REQ-015 Outputs during/after reset: cmd_ready=1, io_acquire_valid=0, io_grant_ready=0, rsp_valid=0, rsp_last=0, busy=0; reset mid-transaction abandons it without emitting further beats.

Verification
REQ-016 Block read addr_block=0x000001, slave returns beats 0..7 with g_type 5, xid 0 -> acquire a_type 1, addr_beat 0, union 0x001; 8 rsp beats, rsp_last only on beat 7; next cmd uses xid 1.
REQ-017 Single read addr_beat=3, acquire_ready delayed 4 cycles -> acquire held stable 5 cycles; one beat rsp_beat=3, rsp_last=1, g_type 4, err flags 0.
REQ-018 rsp_ready low 10 cycles mid-block -> io_grant_ready low same cycles, no beat lost or duplicated, data order preserved.
REQ-019 Grant with xid 2 while expecting 0, or beat 5 while expecting 4 -> err_proto=1 from next cycle, remains 1 until reset.
REQ-020 TIMEOUT_CYCLES=16, no grant after acquire -> err_timeout=1 after 16 GNT cycles, FSM IDLE, cmd_ready=1.
REQ-021 Four back-to-back blocks -> xids 0,1,2,3, then wrap to 0; reset asserted during beat 3 -> all outputs at reset values next cycle.
